// File: rtl/dcache_pkg.sv
// Shared types and sizing for the dcache overhead (tag/valid/dirty) RAM and its controller.
package dcache_pkg;

  localparam int OVERHEAD_MEMORY_SIZE = 8;
  localparam int OVERHEAD_ADDR_WIDTH  = $clog2(OVERHEAD_MEMORY_SIZE);
  localparam int OVERHEAD_TAG_WIDTH   = 6;

  typedef struct packed {
    logic                          valid;
    logic                          dirty;
    logic [OVERHEAD_TAG_WIDTH-1:0] tag;
  } overhead_t;

  localparam int OVERHEAD_WIDTH = $bits(overhead_t);

  typedef enum logic [1:0] {
    OVH_INIT  = 2'd0,
    OVH_RUN   = 2'd1,
    OVH_FLUSH = 2'd2
  } ovh_ctrl_state_t;

  // Last index visited by a sweep, expressed in the widened counter width.
  function automatic logic [OVERHEAD_ADDR_WIDTH:0] sweep_last_idx(input int mem_size);
    sweep_last_idx = (OVERHEAD_ADDR_WIDTH+1)'(mem_size - 1);
  endfunction

endpackage

// File: rtl/dcache_overhead_wr_arb.sv
// Two-way fixed-priority write arbiter onto overhead RAM port A: line fill always beats state update.
module dcache_overhead_wr_arb
  import dcache_pkg::*;
#(
  parameter int ADDR_WIDTH = OVERHEAD_ADDR_WIDTH
) (
  input  logic                  en_i,
  input  logic                  fill_valid_i,
  input  logic [ADDR_WIDTH-1:0] fill_addr_i,
  input  overhead_t             fill_data_i,
  output logic                  fill_ready_o,
  input  logic                  upd_valid_i,
  input  logic [ADDR_WIDTH-1:0] upd_addr_i,
  input  overhead_t             upd_data_i,
  output logic                  upd_ready_o,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output overhead_t             wr_data_o
);

  logic fill_gnt;
  logic upd_gnt;

  assign fill_ready_o = en_i;
  assign upd_ready_o  = en_i & ~fill_valid_i;

  assign fill_gnt = en_i & fill_valid_i;
  assign upd_gnt  = en_i & upd_valid_i & ~fill_valid_i;

  assign wr_en_o   = fill_gnt | upd_gnt;
  assign wr_addr_o = fill_valid_i ? fill_addr_i : upd_addr_i;
  assign wr_data_o = fill_valid_i ? fill_data_i : upd_data_i;

endmodule

// File: rtl/dcache_overhead_ctrl.sv
// Sequencer/arbiter for the dcache overhead SDP RAM: zeroing sweeps, write arbitration, lookups.
// Optional macro DCACHE_OVERHEAD_BYPASS_EN forwards same-cycle write data to a colliding lookup.
module dcache_overhead_ctrl
  import dcache_pkg::*;
#(
  parameter int MEMORY_SIZE = OVERHEAD_MEMORY_SIZE,
  parameter int ADDR_WIDTH  = OVERHEAD_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_req,
  output logic                  init_done,
  output logic                  flush_done,
  input  logic                  lookup_valid,
  output logic                  lookup_ready,
  input  logic [ADDR_WIDTH-1:0] lookup_addr,
  output logic                  lookup_rvalid,
  output overhead_t             lookup_rdata,
  input  logic                  fill_valid,
  output logic                  fill_ready,
  input  logic [ADDR_WIDTH-1:0] fill_addr,
  input  overhead_t             fill_data,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic [ADDR_WIDTH-1:0] upd_addr,
  input  overhead_t             upd_data,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic                  ram_ena,
  output overhead_t             ram_dina,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  output logic                  ram_enb,
  input  overhead_t             ram_doutb
);

  ovh_ctrl_state_t       state_q;
  logic [ADDR_WIDTH:0]   cnt_q;
  logic [ADDR_WIDTH:0]   cnt_d;
  logic                  init_done_q;
  logic                  flush_done_q;
  logic                  rvalid_q;

  logic                  run;
  logic                  sweep;
  logic                  last_sweep;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  overhead_t             wr_data;
  logic                  collision;
  logic                  accept;

  // Outputs are gated by rst so nothing reaches the RAM during a reset cycle.
  assign run        = (state_q == OVH_RUN) & ~rst;
  assign sweep      = (state_q != OVH_RUN) & ~rst;
  assign cnt_d      = cnt_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
  assign last_sweep = (cnt_q == (ADDR_WIDTH+1)'(MEMORY_SIZE - 1));

  dcache_overhead_wr_arb #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_wr_arb (
    .en_i         (run),
    .fill_valid_i (fill_valid),
    .fill_addr_i  (fill_addr),
    .fill_data_i  (fill_data),
    .fill_ready_o (fill_ready),
    .upd_valid_i  (upd_valid),
    .upd_addr_i   (upd_addr),
    .upd_data_i   (upd_data),
    .upd_ready_o  (upd_ready),
    .wr_en_o      (wr_en),
    .wr_addr_o    (wr_addr),
    .wr_data_o    (wr_data)
  );

  assign collision = wr_en & lookup_valid & (wr_addr == lookup_addr);

`ifdef DCACHE_OVERHEAD_BYPASS_EN
  assign lookup_ready = run;
`else
  // The RAM is read-first, so a colliding read is held off one cycle to see the new value.
  assign lookup_ready = run & ~collision;
`endif

  assign accept = lookup_valid & lookup_ready;

  assign ram_ena   = sweep | wr_en;
  assign ram_addra = sweep ? cnt_q[ADDR_WIDTH-1:0] : wr_addr;
  assign ram_dina  = sweep ? overhead_t'('0) : wr_data;
  assign ram_enb   = accept;
  assign ram_addrb = lookup_addr;

  assign init_done     = init_done_q;
  assign flush_done    = flush_done_q;
  assign lookup_rvalid = rvalid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= OVH_INIT;
      cnt_q        <= '0;
      init_done_q  <= 1'b0;
      flush_done_q <= 1'b0;
      rvalid_q     <= 1'b0;
    end else begin
      rvalid_q     <= accept;
      flush_done_q <= 1'b0;
      case (state_q)
        OVH_RUN: begin
          if (flush_req) begin
            state_q     <= OVH_FLUSH;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
          end
        end
        default: begin
          if (last_sweep) begin
            state_q      <= OVH_RUN;
            cnt_q        <= '0;
            init_done_q  <= 1'b1;
            flush_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
      endcase
    end
  end

`ifdef DCACHE_OVERHEAD_BYPASS_EN
  logic      hit_q;
  overhead_t byp_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q      <= 1'b0;
      byp_data_q <= '0;
    end else begin
      hit_q      <= accept & collision;
      byp_data_q <= wr_data;
    end
  end

  assign lookup_rdata = hit_q ? byp_data_q : ram_doutb;
`else
  assign lookup_rdata = ram_doutb;
`endif

endmodule

// File: tb/tb_dcache_overhead_ctrl.sv
// Randomized self-checking bench for dcache_overhead_ctrl against a line-array reference model.
module tb_dcache_overhead_ctrl;
  import dcache_pkg::*;

  localparam int MS = OVERHEAD_MEMORY_SIZE;
  localparam int AW = OVERHEAD_ADDR_WIDTH;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush_req = 1'b0;
  logic          init_done, flush_done;
  logic          lookup_valid = 1'b0;
  logic          lookup_ready;
  logic [AW-1:0] lookup_addr = '0;
  logic          lookup_rvalid;
  overhead_t     lookup_rdata;
  logic          fill_valid = 1'b0;
  logic          fill_ready;
  logic [AW-1:0] fill_addr = '0;
  overhead_t     fill_data = '0;
  logic          upd_valid = 1'b0;
  logic          upd_ready;
  logic [AW-1:0] upd_addr = '0;
  overhead_t     upd_data = '0;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic          ram_ena, ram_enb;
  overhead_t     ram_dina;
  overhead_t     ram_doutb;

  overhead_t     tb_ram [MS];

  int            n_vec = 0;
  int            n_err = 0;
  bit            verbose = 1'b0;

  // Reference model: line contents, sweep cycles left, pending read result.
  logic [7:0]    m_mem [MS];
  int            m_sweep = MS;
  bit            m_fd = 1'b0;
  bit            pv = 1'b0;
  logic [7:0]    pd = '0;

  always #5 clk = ~clk;

  dcache_overhead_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .flush_req     (flush_req),
    .init_done     (init_done),
    .flush_done    (flush_done),
    .lookup_valid  (lookup_valid),
    .lookup_ready  (lookup_ready),
    .lookup_addr   (lookup_addr),
    .lookup_rvalid (lookup_rvalid),
    .lookup_rdata  (lookup_rdata),
    .fill_valid    (fill_valid),
    .fill_ready    (fill_ready),
    .fill_addr     (fill_addr),
    .fill_data     (fill_data),
    .upd_valid     (upd_valid),
    .upd_ready     (upd_ready),
    .upd_addr      (upd_addr),
    .upd_data      (upd_data),
    .ram_addra     (ram_addra),
    .ram_ena       (ram_ena),
    .ram_dina      (ram_dina),
    .ram_addrb     (ram_addrb),
    .ram_enb       (ram_enb),
    .ram_doutb     (ram_doutb)
  );

  // Read-first simple dual-port RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (ram_ena) tb_ram[ram_addra] <= ram_dina;
    if (ram_enb) ram_doutb <= tb_ram[ram_addrb];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    flush_req = 1'b0; fill_valid = 1'b0; upd_valid = 1'b0; lookup_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_sweep = MS; m_fd = 1'b0; pv = 1'b0;
    #1;
    check("rst_init_done", init_done, 0);
    check("rst_flush_done", flush_done, 0);
    check("rst_rvalid", lookup_rvalid, 0);
    check("rst_ready", {fill_ready, upd_ready, lookup_ready}, 0);
    if (verbose) $display("reset applied");
  endtask

  task automatic do_cycle(input bit fv, input int fa, input logic [7:0] fdat,
                          input bit uv, input int ua, input logic [7:0] udat,
                          input bit lv, input int la, input bit fr);
    bit run, wen, coll, acc, exp_lr;
    int wa;
    logic [7:0] wd;
    @(negedge clk);
    fill_valid = fv;   fill_addr = AW'(fa);   fill_data = overhead_t'(fdat);
    upd_valid  = uv;   upd_addr  = AW'(ua);   upd_data  = overhead_t'(udat);
    lookup_valid = lv; lookup_addr = AW'(la); flush_req = fr;
    #1;
    run = (m_sweep == 0);
    wen = 1'b0; coll = 1'b0; acc = 1'b0; wa = 0; wd = '0;
    check("init_done", init_done, run);
    check("flush_done", flush_done, m_fd);
    if (!run) begin
      check("sweep_ready", {fill_ready, upd_ready, lookup_ready}, 0);
      check("sweep_ena", ram_ena, 1);
      check("sweep_addr", ram_addra, MS - m_sweep);
      check("sweep_data", ram_dina, 0);
      check("sweep_enb", ram_enb, 0);
    end else begin
      wen  = fv | uv;
      wa   = fv ? fa : ua;
      wd   = fv ? fdat : udat;
      coll = wen && lv && (wa == la);
`ifdef DCACHE_OVERHEAD_BYPASS_EN
      exp_lr = 1'b1;
`else
      exp_lr = !coll;
`endif
      acc = lv && exp_lr;
      check("fill_ready", fill_ready, 1);
      check("upd_ready", upd_ready, !fv);
      check("lookup_ready", lookup_ready, exp_lr);
      check("ram_ena", ram_ena, wen);
      if (wen) begin
        check("ram_addra", ram_addra, wa);
        check("ram_dina", ram_dina, wd);
      end
      check("ram_enb", ram_enb, acc);
      if (acc) check("ram_addrb", ram_addrb, la);
    end
    @(posedge clk);
    if (run) begin
      pv = acc;
      if (acc) pd = coll ? wd : m_mem[la];
      if (wen) m_mem[wa] = wd;
      m_fd = 1'b0;
      if (fr) m_sweep = MS;
    end else begin
      pv = 1'b0;
      m_sweep--;
      m_fd = (m_sweep == 0);
      if (m_sweep == 0) foreach (m_mem[i]) m_mem[i] = '0;
    end
    #1;
    check("rvalid", lookup_rvalid, pv);
    if (pv) check("rdata", lookup_rdata, pd);
    if (verbose)
      $display("cyc fill=%0b@%0d upd=%0b@%0d look=%0b@%0d flush=%0b -> rvalid=%0b rdata=%02h",
               fv, fa, uv, ua, lv, la, fr, lookup_rvalid, lookup_rdata);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rand_cycle(input int flush_odds);
    do_cycle($urandom_range(0, 1), $urandom_range(0, MS-1), 8'($urandom),
             $urandom_range(0, 1), $urandom_range(0, MS-1), 8'($urandom),
             $urandom_range(0, 3) != 0, $urandom_range(0, MS-1),
             $urandom_range(0, flush_odds) == 0);
  endtask

  initial begin
    for (int i = 0; i < MS; i++) begin
      tb_ram[i] = overhead_t'(8'h80 | 8'(i + 1));
      m_mem[i]  = 8'h80 | 8'(i + 1);
    end
    verbose = 1'b1;

    // Reset mid-sweep: the sweep must restart from line 0.
    do_reset();
    for (int i = 0; i < 4; i++) rand_cycle(1);
    do_reset();
    idle_cycles(MS);

    // Every line reads zero after the initial sweep.
    for (int i = 0; i < MS; i++) do_cycle(0, 0, 0, 0, 0, 0, 1, i, 0);

    // Both writers at once: fill wins, update follows.
    do_cycle(1, 3, 8'h4C, 1, 5, 8'hC7, 0, 0, 0);
    do_cycle(0, 0, 0, 1, 5, 8'hC7, 0, 0, 0);
    do_cycle(0, 0, 0, 0, 0, 0, 1, 5, 0);
    do_cycle(0, 0, 0, 0, 0, 0, 1, 3, 0);

    // Same-address write and lookup, then a retry.
    do_cycle(1, 2, 8'hA5, 0, 0, 0, 1, 2, 0);
    do_cycle(0, 0, 0, 0, 0, 0, 1, 2, 0);

    // Back-to-back lookups.
    do_cycle(0, 0, 0, 0, 0, 0, 1, 0, 0);
    do_cycle(0, 0, 0, 0, 0, 0, 1, 1, 0);
    do_cycle(0, 0, 0, 0, 0, 0, 1, 2, 0);

    // Flush with a lookup accepted in the same cycle, then sweep under random traffic.
    do_cycle(1, 6, 8'h3E, 0, 0, 0, 1, 3, 1);
    for (int i = 0; i < MS; i++) rand_cycle(2);
    for (int i = 0; i < MS; i++) do_cycle(0, 0, 0, 0, 0, 0, 1, i, 0);

    verbose = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      rand_cycle(63);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
